// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data access.
// Data has priority; a starvation counter bounds how long fetch can wait.
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 19,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [3:0] LAT  = 4'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q;
  logic              own_data_q;
  logic [3:0]        cnt_q;
  logic [3:0]        starve_q;
  logic              m_en_q;
  logic              m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_valid_q;
  logic              d_valid_q;

  logic d_req;
  logic any_req;
  logic data_win;

  assign d_req    = d_rd | d_wr;
  assign any_req  = if_req | d_req;
  // Fetch overrides data once it has lost STARVE_MAX grants in a row
  assign data_win = d_req & ~(if_req & (starve_q == SMAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      own_data_q <= 1'b0;
      cnt_q      <= '0;
      starve_q   <= '0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      m_en_q     <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            own_data_q <= data_win;
            m_addr_q   <= data_win ? d_addr : if_addr;
            m_wdata_q  <= d_wdata;
            m_we_q     <= data_win & d_wr;
            m_en_q     <= 1'b1;
            if (data_win && if_req) begin
              if (starve_q != SMAX)
                starve_q <= starve_q + 4'd1;
            end else begin
              starve_q <= '0;
            end
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= LAT;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (own_data_q) begin
              if (!m_we_q)
                d_rdata_q <= m_rdata;
              d_valid_q <= 1'b1;
            end else begin
              if_rdata_q <= m_rdata;
              if_valid_q <= 1'b1;
            end
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign m_en      = m_en_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model of grant order,
// timing and returned data against a latency-accurate memory responder.
module tb_mem_port_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 19;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_rd;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          stall_if;
  logic          stall_mem;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MEM_LAT   (LAT),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .d_rd     (d_rd),
    .d_wr     (d_wr),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_valid  (d_valid),
    .stall_if (stall_if),
    .stall_mem(stall_mem),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  // Memory: unwritten words follow a fixed pattern, writes overlay it
  logic [DW-1:0] wmem [int];
  logic [DW-1:0] pipe [LAT];

  function automatic logic [DW-1:0] base(input int a);
    logic [DW-1:0] v;
    v = DW'(a ^ 'h010) * 19'd37;
    return v ^ 19'h1ABCD;
  endfunction

  function automatic logic [DW-1:0] rd(input int a);
    return wmem.exists(a) ? wmem[a] : base(a);
  endfunction

  // Data is only meaningful exactly LAT cycles after m_en; garbage otherwise
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= (m_en && !m_we) ? rd(int'(m_addr)) : DW'($urandom);
    if (m_en && m_we) wmem[int'(m_addr)] = m_wdata;
  end
  assign m_rdata = pipe[LAT-1];

  int nvec = 0;
  int nerr = 0;
  int starve;
  logic [DW-1:0] exp_if_rd;
  logic [DW-1:0] exp_d_rd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    nvec++;
    assert (obs === want) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chk_quiet();
    chk("idle_m_en", 32'(m_en), 0);
    chk("idle_if_valid", 32'(if_valid), 0);
    chk("idle_d_valid", 32'(d_valid), 0);
    chk("idle_if_rdata", 32'(if_rdata), 32'(exp_if_rd));
    chk("idle_d_rdata", 32'(d_rdata), 32'(exp_d_rd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_quiet();
      @(posedge clk); #1;
    end
  endtask

  // Entered #1 after the edge starting the IDLE cycle; returns #1 after RESP ends
  task automatic txn(input int drop_if_cyc, input int raise_d_cyc,
                     output bit dwin);
    logic [AW-1:0] a;
    bit            we;
    logic [DW-1:0] wd;
    logic [DW-1:0] rdv;
    bit            resp;
    dwin = (d_rd || d_wr) && !(if_req && starve == SMAX);
    if (dwin && if_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
    else starve = 0;
    a   = dwin ? d_addr : if_addr;
    we  = dwin && d_wr;
    wd  = d_wdata;
    rdv = rd(int'(a));
    for (int c = 0; c <= LAT + 2; c++) begin
      if (c == drop_if_cyc) if_req = 1'b0;
      if (c == raise_d_cyc) d_rd = 1'b1;
      @(negedge clk);
      resp = (c == LAT + 2);
      chk("m_en", 32'(m_en), 32'(c == 1));
      if (c == 1) begin
        chk("m_we", 32'(m_we), 32'(we));
        chk("m_addr", 32'(m_addr), 32'(a));
        if (we) chk("m_wdata", 32'(m_wdata), 32'(wd));
      end
      if (resp) begin
        if (!dwin) exp_if_rd = rdv;
        else if (!we) exp_d_rd = rdv;
        chk("m_addr_hold", 32'(m_addr), 32'(a));
        chk("m_we_hold", 32'(m_we), 32'(we));
      end
      chk("if_rdata", 32'(if_rdata), 32'(exp_if_rd));
      chk("d_rdata", 32'(d_rdata), 32'(exp_d_rd));
      chk("if_valid", 32'(if_valid), 32'(resp && !dwin));
      chk("d_valid", 32'(d_valid), 32'(resp && dwin));
      chk("stall_if", 32'(stall_if), 32'(if_req && !(resp && !dwin)));
      chk("stall_mem", 32'(stall_mem),
          32'((d_rd || d_wr) && !(resp && dwin)));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit dw;
    int r;
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    starve = 0; exp_if_rd = '0; exp_d_rd = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_quiet();
    chk("rst_m_we", 32'(m_we), 0);
    chk("rst_m_addr", 32'(m_addr), 0);
    chk("rst_m_wdata", 32'(m_wdata), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // lone fetch
    if_req = 1'b1; if_addr = 12'h010;
    txn(-1, -1, dw);
    chk("lone_owner_if", 32'(dw), 0);
    chk("lone_rdata", 32'(if_rdata), 32'h1ABCD);
    if_req = 1'b0;
    idle(1);

    // simultaneous fetch and data read: data first, fetch right after
    if_req = 1'b1; if_addr = 12'h020; d_rd = 1'b1; d_addr = 12'h200;
    txn(-1, -1, dw);
    chk("simul_first_data", 32'(dw), 1);
    d_rd = 1'b0;
    txn(-1, -1, dw);
    chk("simul_second_if", 32'(dw), 0);
    if_req = 1'b0;
    idle(1);

    // write then read back
    d_wr = 1'b1; d_addr = 12'h0F0; d_wdata = 19'h00055;
    txn(-1, -1, dw);
    d_wr = 1'b0; d_rd = 1'b1;
    txn(-1, -1, dw);
    chk("write_readback", 32'(d_rdata), 32'h00055);
    d_rd = 1'b0;
    idle(1);

    // starvation: fetch held against back-to-back data reads
    if_req = 1'b1; if_addr = 12'h044; d_rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d_addr = AW'($urandom_range(0, 4095));
      txn(-1, -1, dw);
      chk("starve_owner", 32'(dw), 32'((i % 5) != 4));
      if (!dw) if_addr = AW'($urandom_range(0, 4095));
    end
    if_req = 1'b0; d_rd = 1'b0;
    idle(1);

    // fetch withdrawn mid-flight, data read arrives during WAIT
    if_req = 1'b1; if_addr = 12'h0F0;
    txn(2, 3, dw);
    chk("withdraw_owner_if", 32'(dw), 0);
    d_addr = 12'h123;
    txn(-1, -1, dw);
    chk("withdraw_then_data", 32'(dw), 1);
    d_rd = 1'b0;
    idle(1);

    // random traffic; a losing requester keeps its request pending
    for (int i = 0; i < 150; i++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1'b1; if_addr = AW'($urandom_range(0, 63));
      end
      if (!d_rd && !d_wr) begin
        r = $urandom_range(0, 4);
        d_rd = (r == 1 || r == 3); d_wr = (r == 2 || r == 3);
        d_addr = AW'($urandom_range(0, 63)); d_wdata = DW'($urandom);
      end
      if (!if_req && !d_rd && !d_wr) begin
        idle(1);
      end else begin
        txn(($urandom_range(0, 7) == 0) ? 2 : -1, -1, dw);
        if (dw) begin d_rd = 1'b0; d_wr = 1'b0; end
        else if_req = 1'b0;
      end
    end
    if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    idle(1);
    // ensure a nonzero fetch result exists before the reset test
    if_req = 1'b1; if_addr = 12'h010;
    txn(-1, -1, dw);
    if_req = 1'b0;

    // reset during WAIT of a fetch abandons it
    if_req = 1'b1; if_addr = 12'h077;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    starve = 0; exp_if_rd = '0; exp_d_rd = '0;
    @(negedge clk);
    chk_quiet();
    chk("rstmid_m_addr", 32'(m_addr), 0);
    @(posedge clk); #1;
    idle(6);
    if_req = 1'b1; if_addr = 12'h055;
    txn(-1, -1, dw);
    if_req = 1'b0;
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the pipelined processor. The MEM-stage port carries the CU's mem_read and mem_write_en strobes. The block serialises requests through a fixed-latency issue/wait/response FSM, returns read data per port, and generates per-port stall signals for the pipeline registers. Data accesses have priority; a starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_W, 12, address width of both ports and of the memory
DATA_W, 19, data word width
MEM_LAT, 2, memory read latency in cycles, from the m_en cycle to m_rdata valid; legal range 1..15
STARVE_MAX, 4, maximum consecutive data grants while if_req is pending; legal range 1..15

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held high until if_valid
if_addr  in  ADDR_W  fetch address; stable while if_req is high
if_rdata  out  DATA_W  fetched word; valid when if_valid is high
if_valid  out  1  one-cycle completion pulse for fetch
d_rd  in  1  data read request (mem_read); held until d_valid
d_wr  in  1  data write request (mem_write_en); held until d_valid
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  read data; valid when d_valid is high
d_valid  out  1  one-cycle completion pulse for a data read or write
stall_if  out  1  if_req & ~if_valid (combinational)
stall_mem  out  1  (d_rd | d_wr) & ~d_valid (combinational)
m_en  out  1  memory access strobe, exactly one cycle per transaction
m_we  out  1  memory write enable; qualified by m_en
m_addr  out  ADDR_W  memory address; registered
m_wdata  out  DATA_W  memory write data; registered
m_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after the m_en cycle

Behaviour:
- Reset: synchronous. State goes to IDLE. m_en, m_we, if_valid and d_valid are 0. m_addr, m_wdata, if_rdata and d_rdata are 0. The starvation counter is 0. A reset mid-transaction abandons the transaction and no valid pulse is produced.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: remain in IDLE.
  - Otherwise select the owner. DATA wins if (d_rd|d_wr) and not (if_req & starve_cnt==STARVE_MAX). Otherwise IF wins.
  - Latch the owner, m_addr, m_wdata and m_we (m_we=d_wr for DATA, 0 for IF), then go to ISSUE.
- ISSUE: lasts 1 cycle. m_en=1. Load the wait counter with MEM_LAT. Go to WAIT.
- WAIT:
  - Decrement the counter each cycle. Stay for exactly MEM_LAT cycles.
  - On the last WAIT cycle (ISSUE+MEM_LAT), register m_rdata into the owner's rdata register. The other port's rdata register holds its value.
  - Then go to RESP.
- RESP: lasts 1 cycle. The owner's valid is 1. Go to IDLE.
- Latency: with the request visible in IDLE at cycle 0, valid is at cycle MEM_LAT+2. Throughput is one transaction per MEM_LAT+3 cycles.
- Requesters drop or change their request on the edge ending the RESP cycle. IDLE samples the new request state, so there is no double grant.
- Writes follow the same timing. d_valid pulses in RESP and d_rdata is unchanged.
- d_rd and d_wr both high: treated as a write.
- Starvation counter:
  - +1 (saturating at STARVE_MAX) on each DATA grant made while if_req=1.
  - Cleared on any IF grant.
  - Cleared on a DATA grant made while if_req=0.
- A request withdrawn after grant (branch flush) does not abort the transaction. The memory access completes and the valid pulse is still produced; the requester ignores it.
- Only one transaction is in flight at a time. Requests arriving in ISSUE, WAIT or RESP are not sampled until IDLE.
- m_addr, m_wdata and m_we hold their values outside ISSUE.

Test Plan:
- Reset mid-WAIT (rst at cycle 2 of a fetch) -> next cycle state is IDLE, m_en=0, if_valid never pulses, if_rdata=0.
- Lone fetch: if_req=1, if_addr=0x010, memory returns 0x1ABCD, MEM_LAT=2 -> m_en at cycle 1 with m_addr=0x010 and m_we=0; if_valid at cycle 4 with if_rdata=0x1ABCD; stall_if=1 for cycles 0-3.
- Simultaneous request: if_req=1 and d_rd=1 (d_addr=0x200) at cycle 0 -> DATA granted first, d_valid at cycle 4; IF granted at cycle 5, if_valid at cycle 9.
- Write: d_wr=1, d_addr=0x0F0, d_wdata=0x00055 -> m_en=1, m_we=1, m_addr=0x0F0, m_wdata=0x00055 at cycle 1; d_valid at cycle 4; d_rdata unchanged.
- Starvation: if_req held high with back-to-back data reads, STARVE_MAX=4 -> exactly 4 DATA grants, then one IF grant, then DATA resumes; counter returns to 0.
- Withdrawn fetch: if_req dropped at cycle 2 -> transaction completes, if_valid pulses at cycle 4, next IDLE grants a pending d_rd.
